alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameter WORD_WIDTH, default 36, width of A, B and R.
REQ-002 Parameter OPCODE_WIDTH, default 4, width of op_in and op_out.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 half_clock  input  1  phase flag, toggles once per clock rising edge; functional results SHALL NOT depend on its phase.
REQ-006 op_in  input  OPCODE_WIDTH  operation select, sampled every cycle.
REQ-007 A  input  WORD_WIDTH  first operand.
REQ-008 B  input  WORD_WIDTH  second operand.
REQ-009 R  output  WORD_WIDTH  registered result.
REQ-010 op_out  output  OPCODE_WIDTH  op_in delayed to align with R.

Function
REQ-011 The block SHALL be fully pipelined, accepting a new {op_in, A, B} every cycle with no stalls or handshake.
REQ-012 Latency SHALL be exactly 4 clock cycles for every opcode: inputs sampled at edge N appear on R and op_out after edge N+4.
REQ-013 op_out SHALL equal the op_in sampled 4 edges earlier.
REQ-014 Opcode encodings SHALL be: XOR=0, AND=1, OR=2, SRL=3, SRA=4, ADD=5, SUB=6, YES=7, MLO=8, MHI=9.
REQ-015 XOR/AND/OR SHALL be bitwise A^B, A&B, A|B.
REQ-016 SRL SHALL be A logically shifted right by one bit (MSB filled with 0); B ignored.
REQ-017 SRA SHALL be A arithmetically shifted right by one bit (MSB replicated); B ignored.
REQ-018 ADD SHALL be (A+B) mod 2^WORD_WIDTH; carry-out discarded.
REQ-019 SUB SHALL be (A-B) mod 2^WORD_WIDTH (two's complement wrap); borrow discarded.
REQ-020 YES SHALL pass A through unchanged; B ignored.
REQ-021 MLO SHALL be bits [WORD_WIDTH-1:0] of the unsigned 2*WORD_WIDTH-bit product A*B.
REQ-022 MHI SHALL be bits [2*WORD_WIDTH-1:WORD_WIDTH] of the same unsigned product.
REQ-023 Unused opcodes (10-15) SHALL produce R=0; op_out still carries the opcode.
REQ-024 Consecutive operations of different types SHALL not interfere; each result depends only on its own sampled inputs.
REQ-025 The multiplier MAY be split across pipeline stages internally but SHALL meet REQ-012 exactly.

Reset
REQ-026 While reset_n=0, all pipeline registers, R and op_out SHALL be 0, asynchronously from reset_n falling.
REQ-027 After reset_n rises, R and op_out SHALL stay 0 for 4 edges, then present results of inputs sampled from the first post-reset edge onward.
REQ-028 Reset asserted mid-stream SHALL discard all in-flight operations; none emerge after release.

Verification
REQ-029 XOR/AND/OR with A=0xAAAAAAAAA, B=0x555555555 -> R=0xFFFFFFFFF, 0x000000000, 0xFFFFFFFFF, each 4 cycles after issue.
REQ-030 SRL then SRA with A=0x808080808, B=0xFFFFFFFFF -> R=0x404040404 then 0xC04040404.
REQ-031 ADD A=0xFFFFFFFFF, B=0x1 -> R=0x000000000; SUB 2-3 -> 0xFFFFFFFFF; SUB 1-3 -> 0xFFFFFFFFE.
REQ-032 YES A=0x808080808, B=0x101010101 -> R=0x808080808; MLO then MHI with A=B=0x0000FFFFF -> R=0xFFFE00001 then 0x00000000F.
REQ-033 Back-to-back issue of all ten ops one per cycle -> ten consecutive correct results, op_out matching each, regardless of half_clock phase.
REQ-034 Drop reset_n mid-stream -> R=0, op_out=0 immediately; after release, outputs remain 0 for 4 edges then track new inputs.

Source files
------------

// File: rtl/alu.sv
// Four-deep pipelined ALU: logic, shift, add/sub and split 36x36 multiply.
// Every opcode uses the same latency, so R and op_out stay aligned.
module alu #(
  parameter int WORD_WIDTH   = 36,
  parameter int OPCODE_WIDTH = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    half_clock,
  input  logic [OPCODE_WIDTH-1:0] op_in,
  input  logic [WORD_WIDTH-1:0]   A,
  input  logic [WORD_WIDTH-1:0]   B,
  output logic [WORD_WIDTH-1:0]   R,
  output logic [OPCODE_WIDTH-1:0] op_out
);

  localparam int W  = WORD_WIDTH;
  localparam int OW = OPCODE_WIDTH;
  localparam int PW = 2 * W;
  localparam int HW = W / 2;
  localparam int LW = W - HW;

  localparam logic [OW-1:0] OP_XOR = OW'(0);
  localparam logic [OW-1:0] OP_AND = OW'(1);
  localparam logic [OW-1:0] OP_OR  = OW'(2);
  localparam logic [OW-1:0] OP_SRL = OW'(3);
  localparam logic [OW-1:0] OP_SRA = OW'(4);
  localparam logic [OW-1:0] OP_ADD = OW'(5);
  localparam logic [OW-1:0] OP_SUB = OW'(6);
  localparam logic [OW-1:0] OP_YES = OW'(7);
  localparam logic [OW-1:0] OP_MLO = OW'(8);
  localparam logic [OW-1:0] OP_MHI = OW'(9);

  typedef struct packed {
    logic [OW-1:0] op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
  } s1_t;

  typedef struct packed {
    logic [OW-1:0]   op;
    logic [W-1:0]    res;
    logic [HW+W-1:0] plo;
    logic [LW+W-1:0] phi;
  } s2_t;

  typedef struct packed {
    logic [OW-1:0] op;
    logic [W-1:0]  res;
    logic [PW-1:0] prod;
  } s3_t;

  typedef struct packed {
    logic [OW-1:0] op;
    logic [W-1:0]  res;
  } s4_t;

  s1_t s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;
  s4_t s4_d, s4_q;

  // Phase flag is not needed: every stage advances on every edge.
  logic unused_half_clock;
  assign unused_half_clock = half_clock;

  always_comb begin
    s2_d     = '0;
    s2_d.op  = s1_q.op;
    s2_d.plo = (HW + W)'(s1_q.a[HW-1:0]) * (HW + W)'(s1_q.b);
    s2_d.phi = (LW + W)'(s1_q.a[W-1:HW]) * (LW + W)'(s1_q.b);
    unique case (1'b1)
      (s1_q.op == OP_XOR): s2_d.res = s1_q.a ^ s1_q.b;
      (s1_q.op == OP_AND): s2_d.res = s1_q.a & s1_q.b;
      (s1_q.op == OP_OR):  s2_d.res = s1_q.a | s1_q.b;
      (s1_q.op == OP_SRL): s2_d.res = {1'b0, s1_q.a[W-1:1]};
      (s1_q.op == OP_SRA): s2_d.res = {s1_q.a[W-1], s1_q.a[W-1:1]};
      (s1_q.op == OP_ADD): s2_d.res = s1_q.a + s1_q.b;
      (s1_q.op == OP_SUB): s2_d.res = s1_q.a - s1_q.b;
      (s1_q.op == OP_YES): s2_d.res = s1_q.a;
      default:             s2_d.res = '0;
    endcase
  end

  always_comb begin
    s3_d      = '0;
    s3_d.op   = s2_q.op;
    s3_d.res  = s2_q.res;
    s3_d.prod = PW'(s2_q.plo) + (PW'(s2_q.phi) << HW);
  end

  always_comb begin
    s4_d    = '0;
    s4_d.op = s3_q.op;
    unique case (1'b1)
      (s3_q.op == OP_MLO): s4_d.res = s3_q.prod[W-1:0];
      (s3_q.op == OP_MHI): s4_d.res = s3_q.prod[PW-1:W];
      default:             s4_d.res = s3_q.res;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      s4_q   <= '0;
      R      <= '0;
      op_out <= '0;
    end else begin
      s1_q   <= '{op: op_in, a: A, b: B};
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      s4_q   <= s4_d;
      R      <= s4_q.res;
      op_out <= s4_q.op;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed and random checks of the ALU against a plain arithmetic model,
// including reset behaviour and result/opcode alignment.
module tb_alu;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        half_clock = 1'b0;
  logic [3:0]  op_in = '0;
  logic [35:0] A = '0;
  logic [35:0] B = '0;
  logic [35:0] R;
  logic [3:0]  op_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  op;
    logic [35:0] r;
  } exp_t;

  exp_t exp_q[$];

  alu #(.WORD_WIDTH(36), .OPCODE_WIDTH(4)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .half_clock(half_clock),
    .op_in(op_in),
    .A(A),
    .B(B),
    .R(R),
    .op_out(op_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) half_clock <= ~half_clock;

  function automatic logic [35:0] model(
    input logic [3:0] op, input logic [35:0] a, input logic [35:0] b);
    logic [71:0] p;
    p = 72'(a) * 72'(b);
    case (op)
      4'd0: return a ^ b;
      4'd1: return a & b;
      4'd2: return a | b;
      4'd3: return a >> 1;
      4'd4: return 36'($signed(a) >>> 1);
      4'd5: return a + b;
      4'd6: return a - b;
      4'd7: return a;
      4'd8: return p[35:0];
      4'd9: return p[71:36];
      default: return 36'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [35:0] r_exp,
                       input logic [3:0] op_exp);
    checks++;
    assert (R === r_exp) else begin
      errors++;
      $error("FAIL %s R: got %h want %h", tag, R, r_exp);
    end
    checks++;
    assert (op_out === op_exp) else begin
      errors++;
      $error("FAIL %s op_out: got %0d want %0d", tag, op_out, op_exp);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (exp_q.size() > 4) e = exp_q.pop_front();
    else e = '{op: 4'd0, r: 36'd0};
    check(tag, e.r, e.op);
  endtask

  // Issue one op at the next edge; `given` selects a literal expected value.
  task automatic issue(input string tag, input logic [3:0] op,
                       input logic [35:0] a, input logic [35:0] b,
                       input bit given, input logic [35:0] r);
    op_in = op;
    A = a;
    B = b;
    @(posedge clock);
    exp_q.push_back('{op: op, r: given ? r : model(op, a, b)});
    @(negedge clock);
    pop_check(tag);
  endtask

  task automatic rnd(input string tag);
    logic [35:0] a, b;
    a = 36'({$urandom(), $urandom()});
    b = 36'({$urandom(), $urandom()});
    case ($urandom_range(0, 3))
      0: a = '1;
      1: b = 36'd0;
      default: ;
    endcase
    issue(tag, 4'($urandom_range(0, 15)), a, b, 0, '0);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check("reset_hold", 36'd0, 4'd0);
    reset_n = 1'b1;

    issue("xor", 4'd0, 36'hAAAAAAAAA, 36'h555555555, 1, 36'hFFFFFFFFF);
    issue("and", 4'd1, 36'hAAAAAAAAA, 36'h555555555, 1, 36'h000000000);
    issue("or",  4'd2, 36'hAAAAAAAAA, 36'h555555555, 1, 36'hFFFFFFFFF);
    issue("srl", 4'd3, 36'h808080808, 36'hFFFFFFFFF, 1, 36'h404040404);
    issue("sra", 4'd4, 36'h808080808, 36'hFFFFFFFFF, 1, 36'hC04040404);
    issue("add", 4'd5, 36'hFFFFFFFFF, 36'h1, 1, 36'h000000000);
    issue("sub23", 4'd6, 36'h2, 36'h3, 1, 36'hFFFFFFFFF);
    issue("sub13", 4'd6, 36'h1, 36'h3, 1, 36'hFFFFFFFFE);
    issue("yes", 4'd7, 36'h808080808, 36'h101010101, 1, 36'h808080808);
    issue("mlo", 4'd8, 36'h0000FFFFF, 36'h0000FFFFF, 1, 36'hFFFE00001);
    issue("mhi", 4'd9, 36'h0000FFFFF, 36'h0000FFFFF, 1, 36'h00000000F);
    issue("mhi_max", 4'd9, 36'hFFFFFFFFF, 36'hFFFFFFFFF, 1, 36'hFFFFFFFFE);
    issue("mlo_max", 4'd8, 36'hFFFFFFFFF, 36'hFFFFFFFFF, 1, 36'h000000001);
    issue("unused10", 4'd10, 36'h123456789, 36'h1, 1, 36'h0);
    issue("unused15", 4'd15, 36'hFFFFFFFFF, 36'hF, 1, 36'h0);

    // all opcodes back to back, then a drain
    for (int i = 0; i < 16; i++)
      issue("b2b", 4'(i), 36'h9ABCDEF01, 36'h13579BDF1, 0, '0);
    for (int i = 0; i < 200; i++) rnd("rand");

    // async reset mid-stream
    #2 reset_n = 1'b0;
    #1 check("reset_async", 36'd0, 4'd0);
    exp_q.delete();
    @(negedge clock);
    check("reset_held", 36'd0, 4'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 60; i++) rnd("post_reset");
    for (int i = 0; i < 5; i++) issue("drain", 4'd7, 36'(i), 36'd0, 0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
